// File: rtl/xor_memory_rmw_client.sv
// Read-modify-write increment client for one port of the XOR memory, with write-buffer forwarding.
// Optional clamp-on-overflow and sat_flag output when XRMW_SATURATE_EN is defined.
module xor_memory_rmw_client #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int BYPASS_WIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [WIDTH-1:0]         req_delta,
  output logic                     resp_valid,
  output logic [$clog2(DEPTH)-1:0] resp_addr,
  output logic [WIDTH-1:0]         resp_old,
  output logic [WIDTH-1:0]         resp_new,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [WIDTH-1:0]         mem_d,
  output logic                     mem_en,
  input  logic [WIDTH-1:0]         mem_q
`ifdef XRMW_SATURATE_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int AGE_W = $clog2(BYPASS_WIN + 1);

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

  state_t             state_reg, state_next;
  logic [AW-1:0]      addr_reg;
  logic [WIDTH-1:0]   delta_reg;
  logic [WIDTH-1:0]   old_reg;
  logic [WIDTH-1:0]   new_reg;
  logic               byp_valid_reg;
  logic [AW-1:0]      byp_addr_reg;
  logic [WIDTH-1:0]   byp_data_reg;
  logic [AGE_W-1:0]   age_reg;

  logic               accept;
  logic               hit;
  logic               fwd_valid;
  logic [AW-1:0]      fwd_addr;
  logic [WIDTH-1:0]   fwd_data;
  logic [WIDTH-1:0]   add_a, add_b, add_res;

  // While in WR the value being written is not yet in the bypass register, so forward it directly.
  assign fwd_valid = (state_reg == WR) || byp_valid_reg;
  assign fwd_addr  = (state_reg == WR) ? addr_reg : byp_addr_reg;
  assign fwd_data  = (state_reg == WR) ? new_reg  : byp_data_reg;

  assign req_ready = (state_reg == IDLE) || (state_reg == WR);
  assign accept    = req_valid && req_ready;
  assign hit       = accept && fwd_valid && (req_addr == fwd_addr);

  // One adder serves both the memory path (WAIT) and the forwarded path (accept with hit).
  assign add_a = (state_reg == WAIT) ? mem_q     : fwd_data;
  assign add_b = (state_reg == WAIT) ? delta_reg : req_delta;

`ifdef XRMW_SATURATE_EN
  logic [WIDTH:0] sum_wide;
  logic           add_sat;
  logic           sat_reg;
  assign sum_wide = {1'b0, add_a} + {1'b0, add_b};
  assign add_sat  = sum_wide[WIDTH];
  assign add_res  = add_sat ? '1 : sum_wide[WIDTH-1:0];
  assign sat_flag = (state_reg == WR) && sat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_reg <= 1'b0;
    end else if (hit || (state_reg == WAIT)) begin
      sat_reg <= add_sat;
    end
  end
`else
  assign add_res = add_a + add_b;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, WR: begin
        if (accept) state_next = hit ? WR : RD;
        else        state_next = IDLE;
      end
      RD:      state_next = WAIT;
      WAIT:    state_next = WR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      delta_reg     <= '0;
      old_reg       <= '0;
      new_reg       <= '0;
      byp_valid_reg <= 1'b0;
      byp_addr_reg  <= '0;
      byp_data_reg  <= '0;
      age_reg       <= '0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        addr_reg  <= req_addr;
        delta_reg <= req_delta;
        if (hit) begin
          old_reg <= fwd_data;
          new_reg <= add_res;
        end
      end else if (state_reg == WAIT) begin
        old_reg <= mem_q;
        new_reg <= add_res;
      end

      // The bypass covers the memory's one-cycle write buffer, then ages out.
      if (state_reg == WR) begin
        byp_valid_reg <= 1'b1;
        byp_addr_reg  <= addr_reg;
        byp_data_reg  <= new_reg;
        age_reg       <= '0;
      end else if (byp_valid_reg) begin
        age_reg <= age_reg + 1'b1;
        if (age_reg == AGE_W'(BYPASS_WIN - 1)) byp_valid_reg <= 1'b0;
      end
    end
  end

  assign resp_valid = (state_reg == WR);
  assign resp_addr  = addr_reg;
  assign resp_old   = old_reg;
  assign resp_new   = new_reg;
  assign mem_en     = (state_reg == WR);
  assign mem_addr   = addr_reg;
  assign mem_d      = new_reg;

endmodule

// File: tb/tb_xor_memory_rmw_client.sv
// Directed bench for xor_memory_rmw_client with a write-buffered memory model.
// Expected values change with XRMW_SATURATE_EN.
module tb_xor_memory_rmw_client;

  localparam int W  = 8;
  localparam int D  = 256;
  localparam int AW = 8;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_delta;
  logic          resp_valid;
  logic [AW-1:0] resp_addr;
  logic [W-1:0]  resp_old;
  logic [W-1:0]  resp_new;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_d;
  logic          mem_en;
  logic [W-1:0]  mem_q;
`ifdef XRMW_SATURATE_EN
  logic          sat_flag;
`endif

  xor_memory_rmw_client #(.WIDTH(W), .DEPTH(D), .BYPASS_WIN(BW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_delta(req_delta),
    .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_old(resp_old), .resp_new(resp_new),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_en(mem_en), .mem_q(mem_q)
`ifdef XRMW_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: registered read, writes land one cycle late (write buffer).
  logic [W-1:0]  mem_model [D];
  logic          pend_en = 1'b0;
  logic [AW-1:0] pend_addr;
  logic [W-1:0]  pend_d;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;

  always @(posedge clk) begin
    mem_q     <= mem_model[mem_addr];
    pend_en   <= mem_en;
    pend_addr <= mem_addr;
    pend_d    <= mem_d;
    if (pend_en) mem_model[pend_addr] <= pend_d;
    if (ld_en)   mem_model[ld_addr]   <= ld_data;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  logic [W-1:0]  cap_old, cap_new, cap_d;
  logic [AW-1:0] cap_addr, cap_maddr;
  logic          cap_en;
  logic          cap_sat;

  // Present one request from IDLE and wait (bounded) for its response strobe.
  task automatic issue(input int idle, input logic [AW-1:0] a, input logic [W-1:0] d, output int lat);
    repeat (idle) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_delta = d;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    cap_old = resp_old; cap_new = resp_new; cap_addr = resp_addr;
    cap_en = mem_en; cap_d = mem_d; cap_maddr = mem_addr;
`ifdef XRMW_SATURATE_EN
    cap_sat = sat_flag;
`else
    cap_sat = 1'b0;
`endif
    $display("req addr=%0d delta=%0d lat=%0d old=%0d new=%0d", a, d, lat, cap_old, cap_new);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  pre;
    logic [W-1:0]  delta;
    logic [W-1:0]  exp_old;
    logic [W-1:0]  exp_new;
    logic          exp_sat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat;
    int sent, cyc, nresp;
    int            resp_cyc [4];
    logic [W-1:0]  resp_val [4];

    vecs[0] = '{addr: 8'd5,   pre: 8'd10,  delta: 8'd3,   exp_old: 8'd10,  exp_new: 8'd13,  exp_sat: 1'b0};
    vecs[1] = '{addr: 8'd0,   pre: 8'd7,   delta: 8'd0,   exp_old: 8'd7,   exp_new: 8'd7,   exp_sat: 1'b0};
    vecs[2] = '{addr: 8'd255, pre: 8'd100, delta: 8'd55,  exp_old: 8'd100, exp_new: 8'd155, exp_sat: 1'b0};
    vecs[5] = '{addr: 8'd100, pre: 8'h80,  delta: 8'h7F,  exp_old: 8'h80,  exp_new: 8'hFF,  exp_sat: 1'b0};
`ifdef XRMW_SATURATE_EN
    vecs[3] = '{addr: 8'd9,   pre: 8'd250, delta: 8'd10,  exp_old: 8'd250, exp_new: 8'd255, exp_sat: 1'b1};
    vecs[4] = '{addr: 8'd40,  pre: 8'd255, delta: 8'd1,   exp_old: 8'd255, exp_new: 8'd255, exp_sat: 1'b1};
`else
    vecs[3] = '{addr: 8'd9,   pre: 8'd250, delta: 8'd10,  exp_old: 8'd250, exp_new: 8'd4,   exp_sat: 1'b0};
    vecs[4] = '{addr: 8'd40,  pre: 8'd255, delta: 8'd1,   exp_old: 8'd255, exp_new: 8'd0,   exp_sat: 1'b0};
`endif

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_delta = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset req_ready", req_ready, 1);
    check("reset resp_valid", resp_valid, 0);
    check("reset mem_en", mem_en, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_d", mem_d, 0);
    check("reset resp_addr", resp_addr, 0);
    check("reset resp_old", resp_old, 0);
    check("reset resp_new", resp_new, 0);
`ifdef XRMW_SATURATE_EN
    check("reset sat_flag", sat_flag, 0);
`endif

    // Single requests from a cold bypass, distinct addresses.
    for (int i = 0; i < 6; i++) begin
      load(vecs[i].addr, vecs[i].pre);
      issue(3, vecs[i].addr, vecs[i].delta, lat);
      check($sformatf("vec%0d latency", i), lat, 3);
      check($sformatf("vec%0d resp_old", i), cap_old, vecs[i].exp_old);
      check($sformatf("vec%0d resp_new", i), cap_new, vecs[i].exp_new);
      check($sformatf("vec%0d resp_addr", i), cap_addr, vecs[i].addr);
      check($sformatf("vec%0d mem_en", i), cap_en, 1);
      check($sformatf("vec%0d mem_d", i), cap_d, vecs[i].exp_new);
      check($sformatf("vec%0d mem_addr", i), cap_maddr, vecs[i].addr);
`ifdef XRMW_SATURATE_EN
      check($sformatf("vec%0d sat_flag", i), cap_sat, vecs[i].exp_sat);
`endif
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d memory", i), mem_model[vecs[i].addr], vecs[i].exp_new);
    end

    // Four back-to-back increments of the same address: one RD, then consecutive WR cycles.
    load(8'd7, 8'd0);
    sent = 0; cyc = 0; nresp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'd7; req_delta = 8'd1;
    while ((sent < 4 || nresp < 4) && cyc < 20) begin
      if (req_valid && req_ready) sent++;
      @(negedge clk);
      cyc++;
      if (sent == 4) req_valid = 1'b0;
      if (resp_valid && nresp < 4) begin
        resp_cyc[nresp] = cyc;
        resp_val[nresp] = resp_new;
        nresp++;
      end
    end
    req_valid = 1'b0;
    $display("burst addr=7 responses=%0d", nresp);
    check("burst response count", nresp, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < nresp) begin
        check($sformatf("burst%0d resp_new", i), resp_val[i], i + 1);
        check($sformatf("burst%0d cycle", i), resp_cyc[i], i + 3);
      end
    end
    repeat (3) @(negedge clk);
    check("burst memory", mem_model[7], 4);

    // Alternating addresses never hit the bypass.
    load(8'd1, 8'd0);
    load(8'd2, 8'd0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(0, (i % 2 == 1) ? 8'd2 : 8'd1, 8'd1, lat);
      check($sformatf("alt%0d latency", i), lat, 3);
      check($sformatf("alt%0d resp_new", i), cap_new, i / 2 + 1);
    end
    repeat (3) @(negedge clk);
    check("alt memory addr1", mem_model[1], 2);
    check("alt memory addr2", mem_model[2], 2);

    // Bypass window: hit inside the window, RD once it has aged out.
    load(8'd3, 8'd20);
    issue(3, 8'd3, 8'd1, lat);
    check("age first latency", lat, 3);
    check("age first resp_new", cap_new, 21);
    issue(BW - 1, 8'd3, 8'd1, lat);
    check("age hit latency", lat, 1);
    check("age hit resp_old", cap_old, 21);
    check("age hit resp_new", cap_new, 22);
    issue(BW, 8'd3, 8'd1, lat);
    check("age miss latency", lat, 3);
    check("age miss resp_old", cap_old, 22);
    check("age miss resp_new", cap_new, 23);

    // Reset during WAIT drops the request.
    load(8'd12, 8'd50);
    repeat (3) @(negedge clk);
    req_valid = 1'b1; req_addr = 8'd12; req_delta = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst cycle%0d resp_valid", i), resp_valid, 0);
      check($sformatf("rst cycle%0d mem_en", i), mem_en, 0);
      @(negedge clk);
    end
    $display("reset during WAIT addr=12");
    check("rst memory unchanged", mem_model[12], 50);
    issue(0, 8'd12, 8'd5, lat);
    check("rst retry latency", lat, 3);
    check("rst retry resp_new", cap_new, 55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
